// File: rtl/uart_pkg.sv
// uart_pkg: state encoding, default line constants and baud divider derivation shared by the UART blocks
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } uart_state_t;

    localparam int DEFAULT_CLK_FREQ_HZ   = 12_000_000;
    localparam int DEFAULT_BAUD_RATE_BPS = 9600;

    // Cycles per bit, or half of that for the mid-start-bit sample point.
    function automatic int baud_div(input int clk_hz, input int baud_bps, input bit half);
        return half ? (clk_hz / baud_bps) / 2 : clk_hz / baud_bps;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: free-running bit timer giving a one-cycle tick at the half-bit or full-bit point
module uart_bit_timer #(
    parameter int BIT_COUNT  = 1250,
    parameter int HALF_COUNT = 625
) (
    input  logic ice_clk,
    input  logic reset,
    input  logic restart,
    input  logic half,
    output logic tick
);

    localparam int W = $clog2(BIT_COUNT);
    localparam logic [W-1:0] BIT_LAST  = W'(BIT_COUNT - 1);
    localparam logic [W-1:0] HALF_LAST = W'(HALF_COUNT - 1);

    logic [W-1:0] cnt;

    assign tick = cnt == (half ? HALF_LAST : BIT_LAST);

    // Count cycles within a bit; wrap to zero on every tick so the count never passes BIT_COUNT-1.
    always_ff @(posedge ice_clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else
            cnt <= (restart || tick) ? '0 : cnt + 1'b1;
    end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1-style UART receiver with single-entry valid/ready holding buffer and error pulses
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ_HZ   = DEFAULT_CLK_FREQ_HZ,
    parameter int BAUD_RATE_BPS = DEFAULT_BAUD_RATE_BPS,
    parameter int DATA_BITS     = 8,
    parameter int STOP_BITS     = 1
) (
    input  logic                 ice_clk,
    input  logic                 reset,
    input  logic                 rxd_sync,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int BIT_COUNT  = baud_div(CLK_FREQ_HZ, BAUD_RATE_BPS, 1'b0);
    localparam int HALF_COUNT = baud_div(CLK_FREQ_HZ, BAUD_RATE_BPS, 1'b1);
    localparam logic [3:0] DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0] STOP_LAST = 4'(STOP_BITS - 1);

    if (BIT_COUNT < 4) begin : g_bit_count_chk
        $error("uart_rx: BIT_COUNT must be at least 4");
    end
    if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_data_bits_chk
        $error("uart_rx: DATA_BITS must be 5..8");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_stop_bits_chk
        $error("uart_rx: STOP_BITS must be 1 or 2");
    end

    uart_state_t          state, state_n;
    logic [3:0]           idx, idx_n;
    logic [DATA_BITS-1:0] shift, shift_n;
    logic                 commit, ferr, tick, load;

    uart_bit_timer #(
        .BIT_COUNT (BIT_COUNT),
        .HALF_COUNT(HALF_COUNT)
    ) u_timer (
        .ice_clk(ice_clk),
        .reset  (reset),
        .restart(state == IDLE),
        .half   (state == START),
        .tick   (tick)
    );

    assign load = commit && (!rx_valid || rx_ready);

    // Frame sequencing: next state, bit index, shift register and end-of-frame events.
    always_comb begin
        state_n = state;
        idx_n   = idx;
        shift_n = shift;
        commit  = 1'b0;
        ferr    = 1'b0;
        case (state)
            IDLE: begin
                idx_n = '0;
                if (!rxd_sync) state_n = START;
            end
            START: if (tick) state_n = rxd_sync ? IDLE : DATA;
            DATA: if (tick) begin
                shift_n = {rxd_sync, shift[DATA_BITS-1:1]};
                idx_n   = (idx == DATA_LAST) ? '0 : idx + 1'b1;
                if (idx == DATA_LAST) state_n = STOP;
            end
            STOP: if (tick) begin
                idx_n = idx + 1'b1;
                if (!rxd_sync) begin
                    ferr    = 1'b1;
                    state_n = WAIT_IDLE;
                end else if (idx == STOP_LAST) begin
                    commit  = 1'b1;
                    state_n = IDLE;
                end
            end
            WAIT_IDLE: if (rxd_sync) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Register FSM state, datapath, holding buffer and single-cycle status pulses.
    always_ff @(posedge ice_clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            idx       <= '0;
            shift     <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            idx       <= idx_n;
            shift     <= shift_n;
            rx_data   <= load ? shift : rx_data;
            rx_valid  <= load || (rx_valid && !rx_ready);
            frame_err <= ferr;
            overrun   <= commit && rx_valid && !rx_ready;
            busy      <= state_n != IDLE;
        end
    end

endmodule
